boot_stream_tx: RTL

Host-side boot image streamer: the transmitting end of the SPI boot protocol consumed by the SoC boot loader. On `start` it reads an image word by word from a Wishbone-style source memory. It drives a byte-wide SPI master port with the write-mode byte, then each word LSB-first, then the all-ones terminator word. It sits in the programming/test harness FPGA, in front of the SPI master that connects to the target SoC's boot SPI slave.

---
 rtl/boot_pkg.sv | 28 ++
 rtl/boot_gap_timer.sv | 32 +++
 rtl/boot_stream_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared SPI boot protocol constants, state and error encodings.
// Used by the host-side streamer and by the target-side loader.
package boot_pkg;

  localparam logic [7:0]  BOOT_MODE_RD   = 8'h01;
  localparam logic [7:0]  BOOT_MODE_WR   = 8'h02;
  localparam logic [7:0]  BOOT_FILL_BYTE = 8'hFF;
  localparam logic [31:0] BOOT_TERM_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MODE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_GAP   = 3'd4,
    ST_TERM  = 3'd5,
    ST_FIN   = 3'd6,
    ST_ERR   = 3'd7
  } boot_state_e;

  typedef enum logic [1:0] {
    BOOT_ERR_NONE   = 2'd0,
    BOOT_ERR_LEN    = 2'd1,
    BOOT_ERR_TERM   = 2'd2,
    BOOT_ERR_VERIFY = 2'd3
  } boot_err_e;

endpackage

// File: rtl/boot_gap_timer.sv
// Loadable down-counter: expired_o rises GAP_CYCLES clocks after load_i (GAP_CYCLES >= 1).
module boot_gap_timer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/boot_stream_tx.sv
// Host-side boot image streamer: mode byte, image words LSB-first, then the all-ones terminator.
// Define BOOT_STREAM_VERIFY_EN to check the target's word-counter echo on each word's first byte.
module boot_stream_tx
  import boot_pkg::*;
#(
  parameter int SRC_AW     = 10,
  parameter int MAX_WORDS  = 1024,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       i_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       words_sent,
  output logic              o_src_cyc,
  output logic [SRC_AW-1:0] o_src_adr,
  input  logic [31:0]       i_src_dat,
  input  logic              i_src_ack,
  output logic              o_spi_cyc,
  output logic              o_spi_we,
  output logic [7:0]        o_spi_dat,
  input  logic              i_spi_ack,
  input  logic              i_spi_done,
  input  logic [7:0]        i_spi_rx
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  boot_state_e state_q, state_d, ret_q, ret_d;
  boot_err_e   err_code_q, err_code_d;
  logic [15:0] len_q, len_d, k_q, k_d, ws_q, ws_d;
  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  b_q, b_d, term_q, term_d;
  logic [7:0]  spi_dat_q, spi_dat_d;
  logic        spi_cyc_q, spi_cyc_d, spi_wait_q, spi_wait_d;
  logic        src_cyc_q, src_cyc_d;
  logic        err_q, err_d;
  logic        gap_load, gap_expired, xfer_done, verify_bad;
  logic [15:0] k_inc;

  boot_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk       (clk),
    .rst       (rst),
    .load_i    (gap_load),
    .expired_o (gap_expired)
  );

`ifdef BOOT_STREAM_VERIFY_EN
  // The target echoes the index of the previous word while receiving a word's first byte.
  assign verify_bad = (state_q == ST_SEND) && (b_q == 2'd0) && (k_q != 16'd0) &&
                      (i_spi_rx != 8'(k_q - 16'd1));
`else
  logic rx_unused;
  assign rx_unused  = ^i_spi_rx;
  assign verify_bad = 1'b0;
`endif

  assign k_inc = k_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    err_code_d = err_code_q;
    len_d      = len_q;
    k_d        = k_q;
    ws_d       = ws_q;
    shreg_d    = shreg_q;
    b_d        = b_q;
    term_d     = term_q;
    spi_dat_d  = spi_dat_q;
    spi_cyc_d  = spi_cyc_q;
    spi_wait_d = spi_wait_q;
    src_cyc_d  = src_cyc_q;
    err_d      = err_q;
    gap_load   = 1'b0;
    xfer_done  = 1'b0;

    // A done pulse coincident with ack finishes the exchange immediately.
    if (spi_cyc_q) begin
      if (i_spi_ack) begin
        spi_cyc_d = 1'b0;
        if (i_spi_done) xfer_done = 1'b1;
        else            spi_wait_d = 1'b1;
      end
    end else if (spi_wait_q && i_spi_done) begin
      spi_wait_d = 1'b0;
      xfer_done  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (i_len > MAX_LEN) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = BOOT_ERR_LEN;
          end else begin
            state_d    = ST_MODE;
            len_d      = i_len;
            k_d        = 16'd0;
            ws_d       = 16'd0;
            err_d      = 1'b0;
            err_code_d = BOOT_ERR_NONE;
            spi_cyc_d  = 1'b1;
            spi_dat_d  = BOOT_MODE_WR;
          end
        end
      end

      ST_MODE, ST_TERM: begin
        if (xfer_done) begin
          state_d  = ST_GAP;
          ret_d    = state_q;
          gap_load = 1'b1;
        end
      end

      ST_SEND: begin
        if (xfer_done) begin
          if (verify_bad) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = BOOT_ERR_VERIFY;
          end else begin
            state_d  = ST_GAP;
            ret_d    = ST_SEND;
            gap_load = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (src_cyc_q && i_src_ack) begin
          src_cyc_d = 1'b0;
          if (i_src_dat == BOOT_TERM_WORD) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = BOOT_ERR_TERM;
          end else begin
            state_d   = ST_SEND;
            shreg_d   = i_src_dat;
            b_d       = 2'd0;
            spi_cyc_d = 1'b1;
            spi_dat_d = i_src_dat[7:0];
          end
        end
      end

      ST_GAP: begin
        if (gap_expired) begin
          case (ret_q)
            ST_MODE: begin
              if (len_q == 16'd0) begin
                state_d   = ST_TERM;
                term_d    = 2'd0;
                spi_cyc_d = 1'b1;
                spi_dat_d = BOOT_FILL_BYTE;
              end else begin
                state_d   = ST_FETCH;
                src_cyc_d = 1'b1;
              end
            end
            ST_SEND: begin
              if (b_q != 2'd3) begin
                state_d   = ST_SEND;
                shreg_d   = shreg_q >> 8;
                b_d       = b_q + 2'd1;
                spi_cyc_d = 1'b1;
                spi_dat_d = shreg_q[15:8];
              end else begin
                ws_d = ws_q + 16'd1;
                k_d  = k_inc;
                if (k_inc == len_q) begin
                  state_d   = ST_TERM;
                  term_d    = 2'd0;
                  spi_cyc_d = 1'b1;
                  spi_dat_d = BOOT_FILL_BYTE;
                end else begin
                  state_d   = ST_FETCH;
                  src_cyc_d = 1'b1;
                end
              end
            end
            ST_TERM: begin
              if (term_q == 2'd3) begin
                state_d = ST_FIN;
              end else begin
                state_d   = ST_TERM;
                term_d    = term_q + 2'd1;
                spi_cyc_d = 1'b1;
                spi_dat_d = BOOT_FILL_BYTE;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      err_code_q <= BOOT_ERR_NONE;
      len_q      <= 16'd0;
      k_q        <= 16'd0;
      ws_q       <= 16'd0;
      shreg_q    <= 32'd0;
      b_q        <= 2'd0;
      term_q     <= 2'd0;
      spi_dat_q  <= 8'd0;
      spi_cyc_q  <= 1'b0;
      spi_wait_q <= 1'b0;
      src_cyc_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      err_code_q <= err_code_d;
      len_q      <= len_d;
      k_q        <= k_d;
      ws_q       <= ws_d;
      shreg_q    <= shreg_d;
      b_q        <= b_d;
      term_q     <= term_d;
      spi_dat_q  <= spi_dat_d;
      spi_cyc_q  <= spi_cyc_d;
      spi_wait_q <= spi_wait_d;
      src_cyc_q  <= src_cyc_d;
      err_q      <= err_d;
    end
  end

  assign busy       = (state_q inside {ST_MODE, ST_FETCH, ST_SEND, ST_GAP, ST_TERM});
  assign done       = (state_q == ST_FIN);
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign words_sent = ws_q;
  assign o_src_cyc  = src_cyc_q;
  assign o_src_adr  = k_q[SRC_AW-1:0];
  assign o_spi_cyc  = spi_cyc_q;
  assign o_spi_we   = spi_cyc_q;
  assign o_spi_dat  = spi_dat_q;

endmodule
